// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioner: 2-FF synchronizer, stability filter, edge strobes and sticky events.
// Pin step reaches filt_out cfg_limit+3 edges later; no handshakes, every input is sampled each cycle.
module gpio_in_filter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cfg_rise_en,
  input  logic [WIDTH-1:0] cfg_fall_en,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] evt_status,
  output logic             irq
);

  logic [WIDTH-1:0] s1, s2, filt, rise_q, fall_q, evt;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  // A pin is accepted once it has disagreed with filt for more than cfg_limit cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s2[i] != filt[i]) && (cnt[i] >= cfg_limit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      filt   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      filt   <= filt ^ accept;
      // Strobes are registered alongside filt so they coincide with the new level.
      rise_q <= accept & s2;
      fall_q <= accept & ~s2;
      evt    <= (evt & ~evt_clr) | (rise_q & cfg_rise_en) | (fall_q & cfg_fall_en);
    end
  end

  assign filt_out   = filt;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_status = evt;
  assign irq        = |evt;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: edge strobes are checked through a scoreboard, levels and flags directly.
module tb_gpio_in_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pin_in = 8'h00;
  logic [15:0] cfg_limit = 16'd0;
  logic [7:0]  cfg_rise_en = 8'h00;
  logic [7:0]  cfg_fall_en = 8'h00;
  logic [7:0]  evt_clr = 8'h00;
  logic [7:0]  filt_out, rise_pulse, fall_pulse, evt_status;
  logic        irq;

  gpio_in_filter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .cfg_limit(cfg_limit),
    .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en), .evt_clr(evt_clr),
    .filt_out(filt_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_status(evt_status), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  typedef struct {
    int         c;
    logic [7:0] r;
    logic [7:0] f;
  } pulse_t;
  pulse_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [7:0] r, input logic [7:0] f);
    pulse_t p;
    p.c = c; p.r = r; p.f = f;
    sb.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe the DUT shows must match the oldest expected one.
  always @(negedge clk) begin
    if (!done && (rise_pulse != 8'h00 || fall_pulse != 8'h00)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: rise %0h fall %0h at cycle %0d, none expected",
                 rise_pulse, fall_pulse, cyc);
      end else begin
        pulse_t p;
        p = sb.pop_front();
        chk("pulse_cycle", cyc, p.c);
        chk("pulse_rise", {24'h0, rise_pulse}, {24'h0, p.r});
        chk("pulse_fall", {24'h0, fall_pulse}, {24'h0, p.f});
      end
    end
  end

  int c0;

  initial begin
    // 1: reset with all pins high, then unfiltered acceptance
    pin_in = 8'hFF;
    step(2);
    chk("rst_filt", {24'h0, filt_out}, 32'h0);
    chk("rst_rise", {24'h0, rise_pulse}, 32'h0);
    chk("rst_evt", {24'h0, evt_status}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    c0 = cyc;
    expect_pulse(c0 + 3, 8'hFF, 8'h00);
    step(2);
    chk("t1_filt_early", {24'h0, filt_out}, 32'h0);
    step(1);
    chk("t1_filt", {24'h0, filt_out}, 32'hFF);
    step(2);
    chk("t1_evt", {24'h0, evt_status}, 32'h0);

    pin_in = 8'h00;
    expect_pulse(cyc + 3, 8'h00, 8'hFF);
    step(4);

    // 2: debounce with limit 10; 10-cycle glitch on pin 1 is rejected
    cfg_limit = 16'd10;
    pin_in = 8'h03;
    c0 = cyc;
    expect_pulse(c0 + 13, 8'h01, 8'h00);
    step(10);
    pin_in = 8'h01;
    step(2);
    chk("t2_filt_12", {24'h0, filt_out}, 32'h0);
    step(1);
    chk("t2_filt_13", {24'h0, filt_out}, 32'h01);
    step(15);
    chk("t2_glitch", {24'h0, filt_out}, 32'h01);

    // 3: edge enables select which edges set flags
    cfg_limit = 16'd0;
    cfg_rise_en = 8'h01;
    cfg_fall_en = 8'h02;
    pin_in = 8'h03;
    expect_pulse(cyc + 3, 8'h02, 8'h00);
    step(4);
    pin_in = 8'h02;
    expect_pulse(cyc + 3, 8'h00, 8'h01);
    step(4);
    chk("t3_evt_none", {24'h0, evt_status}, 32'h0);
    pin_in = 8'h03;
    expect_pulse(cyc + 3, 8'h01, 8'h00);
    step(4);
    pin_in = 8'h01;
    expect_pulse(cyc + 3, 8'h00, 8'h02);
    step(4);
    chk("t3_evt", {24'h0, evt_status}, 32'h03);
    chk("t3_irq", {31'h0, irq}, 32'h1);

    // 4: set beats clear in the same cycle
    pin_in = 8'h00;
    expect_pulse(cyc + 3, 8'h00, 8'h01);
    step(4);
    pin_in = 8'h01;
    c0 = cyc;
    expect_pulse(c0 + 3, 8'h01, 8'h00);
    step(3);
    evt_clr = 8'h01;
    step(1);
    evt_clr = 8'h00;
    chk("t4_race", {24'h0, evt_status}, 32'h03);
    evt_clr = 8'h03;
    step(1);
    evt_clr = 8'h00;
    chk("t4_clr", {24'h0, evt_status}, 32'h0);
    chk("t4_irq", {31'h0, irq}, 32'h0);

    // 5: reset in the middle of a long filter restarts the count
    cfg_limit = 16'd100;
    pin_in = 8'h05;
    step(50);
    rst_n = 1'b0;
    step(1);
    chk("t5_rst_filt", {24'h0, filt_out}, 32'h0);
    chk("t5_rst_evt", {24'h0, evt_status}, 32'h0);
    rst_n = 1'b1;
    c0 = cyc;
    expect_pulse(c0 + 103, 8'h05, 8'h00);
    step(102);
    chk("t5_filt_102", {24'h0, filt_out}, 32'h0);
    step(1);
    chk("t5_filt_103", {24'h0, filt_out}, 32'h05);

    // 6: lowering the limit below the running count accepts on the next edge
    cfg_limit = 16'd0;
    pin_in = 8'h00;
    expect_pulse(cyc + 3, 8'h00, 8'h05);
    step(4);
    cfg_limit = 16'd200;
    pin_in = 8'h04;
    c0 = cyc;
    step(152);
    chk("t6_filt_hold", {24'h0, filt_out}, 32'h0);
    cfg_limit = 16'd20;
    expect_pulse(c0 + 153, 8'h04, 8'h00);
    step(1);
    chk("t6_filt", {24'h0, filt_out}, 32'h04);
    step(5);

    chk("sb_empty", sb.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
